anim_sequencer: RTL and testbench

Parametrised sprite-animation sequencer for the fighter datapath. It replaces the fixed single-animation run FSMs. It arbitrates between NUM_ANIMS animations (looping moves such as run, and one-shot moves such as punch and kick), steps frames at a programmable hold rate on frame_clk, and drives the frame index that the sprite ROM address logic consumes.

---
 rtl/anim_sequencer.sv | 156 +++++++++++++++
 tb/tb_anim_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/anim_sequencer.sv
// Sprite-animation sequencer: arbitrates looping and one-shot animation channels
// and steps the frame index at a programmable hold rate on frame_clk.
module anim_sequencer #(
    parameter int unsigned NUM_ANIMS = 4,
    parameter int unsigned FRAME_W = 3,
    parameter int unsigned HOLD_W = 5,
    parameter int unsigned HOLD_TICKS = 11,
    parameter logic [NUM_ANIMS*FRAME_W-1:0] ANIM_LEN = {3'd4, 3'd3, 3'd5, 3'd4},
    parameter logic [NUM_ANIMS-1:0] ONESHOT_MASK = 4'b1110,
    parameter int unsigned ID_W = (NUM_ANIMS > 1) ? $clog2(NUM_ANIMS) : 1
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [NUM_ANIMS-1:0] req,
    input  logic                 freeze,
    output logic [ID_W-1:0]      anim_id,
    output logic [FRAME_W-1:0]   frame,
    output logic                 active,
    output logic                 new_frame,
    output logic                 done
);

    localparam logic StIdle = 1'b0;
    localparam logic StPlay = 1'b1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    if (HOLD_TICKS < 1 || HOLD_TICKS > (2 ** HOLD_W) - 1) begin : g_bad_hold
        $error("anim_sequencer: HOLD_TICKS out of range");
    end
    for (genvar g = 0; g < NUM_ANIMS; g++) begin : g_len_chk
        if (ANIM_LEN[g*FRAME_W +: FRAME_W] == '0) begin : g_bad_len
            $error("anim_sequencer: ANIM_LEN entry is zero");
        end
    end

    logic                 state_q, state_d;
    logic [ID_W-1:0]      anim_id_q, anim_id_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 new_frame_q, new_frame_d;
    logic                 done_q, done_d;
    logic [NUM_ANIMS-1:0] req_q;

    // One-shots start on a rising edge, loops on the level.
    logic [NUM_ANIMS-1:0] os_start;
    logic [NUM_ANIMS-1:0] start_vec;
    logic                 start_any, os_any;
    logic [ID_W-1:0]      start_sel, os_sel;
    logic [FRAME_W-1:0]   cur_len;
    logic                 cur_oneshot;

    assign os_start    = req & ~req_q & ONESHOT_MASK;
    assign start_vec   = os_start | (req & ~ONESHOT_MASK);
    assign cur_oneshot = ONESHOT_MASK[anim_id_q];

    always_comb begin
        start_any = 1'b0;
        start_sel = '0;
        os_any    = 1'b0;
        os_sel    = '0;
        cur_len   = '0;
        for (int i = 0; i < int'(NUM_ANIMS); i++) begin
            if (start_vec[i]) begin
                start_any = 1'b1;
                start_sel = ID_W'(i);
            end
            if (os_start[i]) begin
                os_any = 1'b1;
                os_sel = ID_W'(i);
            end
            if (anim_id_q == ID_W'(i)) begin
                cur_len = ANIM_LEN[i*FRAME_W +: FRAME_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        anim_id_d   = anim_id_q;
        frame_d     = frame_q;
        hold_d      = hold_q;
        new_frame_d = 1'b0;
        done_d      = 1'b0;
        if (!freeze) begin
            case (state_q)
                StIdle: begin
                    if (start_any) begin
                        state_d     = StPlay;
                        anim_id_d   = start_sel;
                        frame_d     = FRAME_W'(1);
                        hold_d      = '0;
                        new_frame_d = 1'b1;
                    end
                end
                StPlay: begin
                    // Preempt beats a simultaneous loop drop; one-shots are uninterruptible.
                    if (!cur_oneshot && os_any && (os_sel > anim_id_q)) begin
                        anim_id_d   = os_sel;
                        frame_d     = FRAME_W'(1);
                        hold_d      = '0;
                        new_frame_d = 1'b1;
                    end else if (!cur_oneshot && !req[anim_id_q]) begin
                        state_d   = StIdle;
                        anim_id_d = '0;
                        frame_d   = '0;
                        hold_d    = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (frame_q < cur_len) begin
                            frame_d     = frame_q + FRAME_W'(1);
                            new_frame_d = 1'b1;
                        end else if (!cur_oneshot) begin
                            frame_d     = FRAME_W'(1);
                            new_frame_d = 1'b1;
                        end else begin
                            state_d   = StIdle;
                            anim_id_d = '0;
                            frame_d   = '0;
                            done_d    = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            anim_id_q   <= '0;
            frame_q     <= '0;
            hold_q      <= '0;
            new_frame_q <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= '0;
        end else begin
            state_q     <= state_d;
            anim_id_q   <= anim_id_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            new_frame_q <= new_frame_d;
            done_q      <= done_d;
            req_q       <= req;
        end
    end

    assign anim_id   = anim_id_q;
    assign frame     = frame_q;
    assign active    = (state_q == StPlay);
    assign new_frame = new_frame_q;
    assign done      = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer: loops, one-shots, preemption, freeze, reset
// and a fast-hold single-frame loop on a second instance.
module tb_anim_sequencer;

    localparam logic [11:0] LEN_A = {3'd4, 3'd5, 3'd3, 3'd4};
    localparam logic [11:0] LEN_B = {3'd4, 3'd5, 3'd3, 3'd1};

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [3:0] req, req2;
    logic       freeze;
    logic [1:0] anim_id, anim_id2;
    logic [2:0] frame, frame2;
    logic       active, active2, new_frame, new_frame2, done, done2;

    int tests = 0;
    int fails = 0;

    always #5 frame_clk = ~frame_clk;

    anim_sequencer #(
        .ANIM_LEN (LEN_A)
    ) u_dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .req       (req),
        .freeze    (freeze),
        .anim_id   (anim_id),
        .frame     (frame),
        .active    (active),
        .new_frame (new_frame),
        .done      (done)
    );

    anim_sequencer #(
        .HOLD_TICKS (1),
        .ANIM_LEN   (LEN_B)
    ) u_dut2 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .req       (req2),
        .freeze    (1'b0),
        .anim_id   (anim_id2),
        .frame     (frame2),
        .active    (active2),
        .new_frame (new_frame2),
        .done      (done2)
    );

    function automatic logic [7:0] pk(input int id, input int fr, input bit a, input bit nf,
                                      input bit d);
        pk = {id[1:0], fr[2:0], a, nf, d};
    endfunction

    // Packed view is {anim_id, frame, active, new_frame, done}.
    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {anim_id, frame, active, new_frame, done};
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {anim_id2, frame2, active2, new_frame2, done2};
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        #1;
        chk(tag, pk(0, 0, 0, 0, 0));
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset  = 1'b1;
        req    = '0;
        req2   = '0;
        freeze = 1'b0;
        #3;
        chk("reset_state", pk(0, 0, 0, 0, 0));
        tick(1);
        Reset = 1'b0;
        tick(1);
        chk("idle_after_reset", pk(0, 0, 0, 0, 0));

        // Loop on anim 0
        req = 4'b0001;
        tick(1);
        chk("loop_t0", pk(0, 1, 1, 1, 0));
        tick(10);
        chk("loop_t10", pk(0, 1, 1, 0, 0));
        tick(1);
        chk("loop_t11", pk(0, 2, 1, 1, 0));
        tick(22);
        chk("loop_t33", pk(0, 4, 1, 1, 0));
        tick(11);
        chk("loop_wrap_t44", pk(0, 1, 1, 1, 0));
        tick(5);
        req = 4'b0000;
        tick(1);
        chk("loop_drop_t50", pk(0, 0, 0, 0, 0));
        tick(1);
        chk("loop_drop_nodone", pk(0, 0, 0, 0, 0));

        // One-shot anim 2, five frames
        req = 4'b0100;
        tick(1);
        chk("os_t0", pk(2, 1, 1, 1, 0));
        req = 4'b0000;
        tick(44);
        chk("os_t44", pk(2, 5, 1, 1, 0));
        tick(6);
        req = 4'b0100;
        tick(4);
        chk("os_t54", pk(2, 5, 1, 0, 0));
        tick(1);
        chk("os_done_t55", pk(0, 0, 0, 0, 1));
        tick(1);
        chk("os_done_once", pk(0, 0, 0, 0, 0));
        tick(1);
        chk("os_held_no_restart", pk(0, 0, 0, 0, 0));
        req = 4'b0000;
        tick(1);
        req = 4'b0100;
        tick(1);
        chk("os_fresh_edge", pk(2, 1, 1, 1, 0));
        do_reset("reset_mid_os");

        // Preempt loop 0 at frame 3 with one-shot 3
        req = 4'b0001;
        tick(1);
        chk("pre_loop_t0", pk(0, 1, 1, 1, 0));
        tick(22);
        chk("pre_loop_f3", pk(0, 3, 1, 1, 0));
        req = 4'b1001;
        tick(1);
        chk("preempt", pk(3, 1, 1, 1, 0));
        tick(43);
        chk("preempt_last", pk(3, 4, 1, 0, 0));
        tick(1);
        chk("preempt_done", pk(0, 0, 0, 0, 1));
        tick(1);
        chk("loop_resume", pk(0, 1, 1, 1, 0));
        req = 4'b0000;
        tick(1);
        chk("loop_resume_drop", pk(0, 0, 0, 0, 0));

        // Priority, then uninterruptible one-shot
        req = 4'b0110;
        tick(1);
        chk("prio_hi", pk(2, 1, 1, 1, 0));
        req = 4'b0000;
        tick(5);
        req = 4'b1000;
        tick(1);
        chk("os_ignores_edge", pk(2, 1, 1, 0, 0));
        req = 4'b0000;
        tick(48);
        chk("os_all5", pk(2, 5, 1, 0, 0));
        tick(1);
        chk("os_uninterrupted_done", pk(0, 0, 0, 0, 1));
        tick(1);
        chk("os_idle_after", pk(0, 0, 0, 0, 0));

        // Freeze mid-frame, then async reset
        req = 4'b0010;
        tick(1);
        chk("frz_t0", pk(1, 1, 1, 1, 0));
        req = 4'b0000;
        tick(11);
        chk("frz_f2", pk(1, 2, 1, 1, 0));
        tick(5);
        freeze = 1'b1;
        tick(1);
        chk("frz_first", pk(1, 2, 1, 0, 0));
        tick(19);
        chk("frz_last", pk(1, 2, 1, 0, 0));
        freeze = 1'b0;
        tick(5);
        chk("frz_rel5", pk(1, 2, 1, 0, 0));
        tick(1);
        chk("frz_rel6", pk(1, 3, 1, 1, 0));
        tick(3);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset", pk(0, 0, 0, 0, 0));
        tick(1);
        chk("reset_no_done", pk(0, 0, 0, 0, 0));
        Reset = 1'b0;

        // HOLD_TICKS=1, single-frame loop
        tick(1);
        req2 = 4'b0001;
        tick(1);
        chk2("fast_t0", pk(0, 1, 1, 1, 0));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk2("fast_repeat", pk(0, 1, 1, 1, 0));
        end
        req2 = 4'b0000;
        tick(1);
        chk2("fast_drop", pk(0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
